// File: rtl/bbc_mem_pkg.sv
// Shared constants, slot types and address-mapping helpers for the bbc SRAM controller.
package bbc_mem_pkg;

  localparam int unsigned PHASES   = 16;
  localparam int unsigned SLOT_LEN = 4;

  localparam logic [15:0] BANK_BASE = 16'h8000;
  localparam logic [15:0] MOS_BASE  = 16'hC000;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_CPU,
    SLOT_VID
  } slot_e;

  // Sideways window goes to the upper half of the SRAM, everything else maps flat.
  function automatic logic [18:0] map_cpu_addr(input logic [15:0] adr, input logic [3:0] romsel);
    if (adr >= BANK_BASE && adr < MOS_BASE) begin
      return {1'b1, romsel, adr[13:0]};
    end
    return {3'b000, adr};
  endfunction

  function automatic logic [18:0] map_vid_addr(input logic [14:0] vadr);
    return {4'b0000, vadr};
  endfunction

  // Which slot a phase belongs to; offsets wrap modulo 16.
  function automatic slot_e slot_of(input logic [3:0] ph, input logic [3:0] cpu_first,
                                    input logic [3:0] vid_first);
    logic [3:0] dc;
    logic [3:0] dv;
    dc = ph - cpu_first;
    dv = ph - vid_first;
    if (dc < 4'(SLOT_LEN)) return SLOT_CPU;
    if (dv < 4'(SLOT_LEN)) return SLOT_VID;
    return SLOT_IDLE;
  endfunction

endpackage

// File: rtl/bbc_mem_map.sv
// CPU address decoder: 6502 address + ROMSEL -> SRAM address and write permission.
module bbc_mem_map
  import bbc_mem_pkg::*;
#(
  parameter logic [15:0] SWRAM_MASK = 16'h00F0
) (
  input  logic [15:0] adr_i,
  input  logic [3:0]  romsel_i,
  output logic [18:0] sram_a_o,
  output logic        write_ok_o
);

  // RAM is always writable, sideways banks only when enabled, MOS never.
  always_comb begin
    sram_a_o   = map_cpu_addr(adr_i, romsel_i);
    write_ok_o = 1'b0;
    if (adr_i < BANK_BASE) begin
      write_ok_o = 1'b1;
    end else if (adr_i < MOS_BASE) begin
      write_ok_o = SWRAM_MASK[romsel_i];
    end
  end

endmodule

// File: rtl/bbc_sram_ctrl.sv
// SRAM responder: CPU and video slots time-multiplexed inside each 16-clock CPU cycle.
module bbc_sram_ctrl
  import bbc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 19,
  parameter logic [15:0] SWRAM_MASK = 16'h00F0,
  parameter int unsigned CPU_PH     = 1,
  parameter int unsigned VID_PH     = 9
) (
  input  logic              CLOCK,
  input  logic              nRESET,
  input  logic              MEM_SYNC,
  input  logic [15:0]       MEM_ADR,
  input  logic              MEM_WE,
  input  logic [7:0]        MEM_DO,
  input  logic [3:0]        ROMSEL,
  output logic [7:0]        MEM_DI,
  input  logic [14:0]       VID_ADR,
  output logic [7:0]        VID_DI,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [7:0]        SRAM_DO,
  output logic              SRAM_DQ_OE,
  input  logic [7:0]        SRAM_DI,
  output logic              SRAM_nCE,
  output logic              SRAM_nOE,
  output logic              SRAM_nWE
);

  localparam logic [3:0] CPU_FIRST = 4'(CPU_PH);
  localparam logic [3:0] CPU_LAST  = 4'(CPU_PH + SLOT_LEN - 1);
  localparam logic [3:0] VID_FIRST = 4'(VID_PH);
  localparam logic [3:0] VID_LAST  = 4'(VID_PH + SLOT_LEN - 1);
  localparam logic [3:0] SYNC_PH   = 4'(PHASES - 1);

  logic [3:0]        phase_q, phase_d;
  logic              abort;
  slot_e             slot_d;
  logic [3:0]        cpu_off;
  logic [18:0]       map_a;
  logic              map_wr_ok;
  logic              cpu_wr_q, cpu_wr_d;
  logic [ADDR_W-1:0] sram_a_q, sram_a_d;
  logic [7:0]        sram_do_q, sram_do_d;
  logic              dq_oe_q, dq_oe_d;
  logic              nce_q, nce_d;
  logic              noe_q, noe_d;
  logic              nwe_q, nwe_d;
  logic [7:0]        mem_di_q, mem_di_d;
  logic [7:0]        vid_di_q, vid_di_d;

  bbc_mem_map #(
    .SWRAM_MASK(SWRAM_MASK)
  ) u_map (
    .adr_i     (MEM_ADR),
    .romsel_i  (ROMSEL),
    .sram_a_o  (map_a),
    .write_ok_o(map_wr_ok)
  );

  // Phase advance; an early MEM_SYNC realigns to 0 and aborts the current slot.
  always_comb begin
    phase_d = MEM_SYNC ? '0 : phase_q + 4'd1;
    abort   = MEM_SYNC && (phase_q != SYNC_PH);
  end

  // Strobes are registered from the next phase so they line up with phase_q; the
  // request is sampled on the clock that enters each slot and held for its duration.
  always_comb begin
    slot_d    = slot_of(phase_d, CPU_FIRST, VID_FIRST);
    cpu_off   = phase_d - CPU_FIRST;
    sram_a_d  = sram_a_q;
    sram_do_d = sram_do_q;
    cpu_wr_d  = cpu_wr_q;
    nce_d     = 1'b1;
    noe_d     = 1'b1;
    nwe_d     = 1'b1;
    dq_oe_d   = 1'b0;
    mem_di_d  = mem_di_q;
    vid_di_d  = vid_di_q;

    unique case (slot_d)
      SLOT_CPU: begin
        if (phase_d == CPU_FIRST) begin
          sram_a_d  = ADDR_W'(map_a);
          sram_do_d = MEM_DO;
          cpu_wr_d  = MEM_WE && map_wr_ok;
        end
        nce_d   = 1'b0;
        noe_d   = cpu_wr_d;
        dq_oe_d = cpu_wr_d;
        nwe_d   = !(cpu_wr_d && (cpu_off == 4'd1 || cpu_off == 4'd2));
      end
      SLOT_VID: begin
        if (phase_d == VID_FIRST) begin
          sram_a_d = ADDR_W'(map_vid_addr(VID_ADR));
        end
        nce_d = 1'b0;
        noe_d = 1'b0;
      end
      default: ;
    endcase

    if (!abort && phase_q == CPU_LAST && !cpu_wr_q) begin
      mem_di_d = SRAM_DI;
    end
    if (!abort && phase_q == VID_LAST) begin
      vid_di_d = SRAM_DI;
    end
  end

  // State, SRAM strobe and capture registers.
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      phase_q   <= '0;
      cpu_wr_q  <= 1'b0;
      sram_a_q  <= '0;
      sram_do_q <= '0;
      dq_oe_q   <= 1'b0;
      nce_q     <= 1'b1;
      noe_q     <= 1'b1;
      nwe_q     <= 1'b1;
      mem_di_q  <= '0;
      vid_di_q  <= '0;
    end else begin
      phase_q   <= phase_d;
      cpu_wr_q  <= cpu_wr_d;
      sram_a_q  <= sram_a_d;
      sram_do_q <= sram_do_d;
      dq_oe_q   <= dq_oe_d;
      nce_q     <= nce_d;
      noe_q     <= noe_d;
      nwe_q     <= nwe_d;
      mem_di_q  <= mem_di_d;
      vid_di_q  <= vid_di_d;
    end
  end

  assign MEM_DI     = mem_di_q;
  assign VID_DI     = vid_di_q;
  assign SRAM_A     = sram_a_q;
  assign SRAM_DO    = sram_do_q;
  assign SRAM_DQ_OE = dq_oe_q;
  assign SRAM_nCE   = nce_q;
  assign SRAM_nOE   = noe_q;
  assign SRAM_nWE   = nwe_q;

endmodule

// File: tb/tb_bbc_sram_ctrl.sv
// Directed bench for bbc_sram_ctrl with a behavioural 512Kx8 SRAM.
module tb_bbc_sram_ctrl;

  logic        CLOCK = 1'b0;
  logic        nRESET;
  logic        MEM_SYNC;
  logic [15:0] MEM_ADR;
  logic        MEM_WE;
  logic [7:0]  MEM_DO;
  logic [3:0]  ROMSEL;
  logic [7:0]  MEM_DI;
  logic [14:0] VID_ADR;
  logic [7:0]  VID_DI;
  logic [18:0] SRAM_A;
  logic [7:0]  SRAM_DO;
  logic        SRAM_DQ_OE;
  logic [7:0]  SRAM_DI;
  logic        SRAM_nCE;
  logic        SRAM_nOE;
  logic        SRAM_nWE;

  int n_cmp = 0;
  int n_err = 0;
  int ph    = 0;
  int wr_lows = 0;
  int wr0;

  logic [7:0] mem [0:524287];

  bbc_sram_ctrl #(
    .ADDR_W(19), .SWRAM_MASK(16'h00F0), .CPU_PH(1), .VID_PH(9)
  ) dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .MEM_SYNC(MEM_SYNC), .MEM_ADR(MEM_ADR),
    .MEM_WE(MEM_WE), .MEM_DO(MEM_DO), .ROMSEL(ROMSEL), .MEM_DI(MEM_DI),
    .VID_ADR(VID_ADR), .VID_DI(VID_DI), .SRAM_A(SRAM_A), .SRAM_DO(SRAM_DO),
    .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_DI(SRAM_DI), .SRAM_nCE(SRAM_nCE),
    .SRAM_nOE(SRAM_nOE), .SRAM_nWE(SRAM_nWE)
  );

  always #5 CLOCK = ~CLOCK;

  // SRAM model: read while selected and output-enabled, write mid-cycle while strobed.
  assign SRAM_DI = (!SRAM_nCE && !SRAM_nOE) ? mem[SRAM_A] : 8'h00;

  always @(negedge CLOCK) begin
    if (!SRAM_nWE) begin
      wr_lows = wr_lows + 1;
      if (!SRAM_nCE && SRAM_DQ_OE) mem[SRAM_A] = SRAM_DO;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; afterwards ph is the phase the DUT is in, and MEM_SYNC marks phase 15.
  task automatic step();
    @(posedge CLOCK);
    #1;
    ph = (MEM_SYNC || !nRESET) ? 0 : (ph + 1) % 16;
    MEM_SYNC = (ph == 15);
    chk("no_oe_overlap", 32'(!SRAM_nOE && SRAM_DQ_OE), 32'd0);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 32 && ph != target; i++) step();
    chk("run_to_phase", 32'(ph), 32'(target));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_di"}, 32'(MEM_DI), 32'h00);
    chk({tag, "_vid_di"}, 32'(VID_DI), 32'h00);
    chk({tag, "_sram_a"}, 32'(SRAM_A), 32'h0);
    chk({tag, "_sram_do"}, 32'(SRAM_DO), 32'h00);
    chk({tag, "_dq_oe"}, 32'(SRAM_DQ_OE), 32'd0);
    chk({tag, "_nce"}, 32'(SRAM_nCE), 32'd1);
    chk({tag, "_noe"}, 32'(SRAM_nOE), 32'd1);
    chk({tag, "_nwe"}, 32'(SRAM_nWE), 32'd1);
  endtask

  initial begin
    nRESET = 1'b0; MEM_SYNC = 1'b0; MEM_ADR = 16'h1234; MEM_WE = 1'b0;
    MEM_DO = 8'h00; ROMSEL = 4'd0; VID_ADR = 15'h7FFF;
    mem[19'h01234] = 8'hA5;
    mem[19'h07FFF] = 8'h5A;
    mem[19'h48001] = 8'h11;
    mem[19'h0C000] = 8'h22;
    mem[19'h00100] = 8'h55;
    mem[19'h54001] = 8'h00;

    step(); step();
    chk_reset_vals("rst");
    nRESET = 1'b1;

    // 1: CPU read of RAM
    step();
    chk("t1_a_ph1", 32'(SRAM_A), 32'h01234);
    chk("t1_nce_ph1", 32'(SRAM_nCE), 32'd0);
    chk("t1_noe_ph1", 32'(SRAM_nOE), 32'd0);
    chk("t1_nwe_ph1", 32'(SRAM_nWE), 32'd1);
    chk("t1_dqoe_ph1", 32'(SRAM_DQ_OE), 32'd0);
    run_to(4);
    chk("t1_a_ph4", 32'(SRAM_A), 32'h01234);
    chk("t1_memdi_ph4", 32'(MEM_DI), 32'h00);
    step();
    chk("t1_memdi_ph5", 32'(MEM_DI), 32'hA5);
    chk("t1_nce_idle", 32'(SRAM_nCE), 32'd1);

    // 4: video read
    run_to(9);
    chk("t4_a_ph9", 32'(SRAM_A), 32'h07FFF);
    chk("t4_noe_ph9", 32'(SRAM_nOE), 32'd0);
    chk("t4_nce_ph9", 32'(SRAM_nCE), 32'd0);
    run_to(12);
    chk("t4_a_ph12", 32'(SRAM_A), 32'h07FFF);
    chk("t4_viddi_ph12", 32'(VID_DI), 32'h00);
    step();
    chk("t4_viddi_ph13", 32'(VID_DI), 32'h5A);
    chk("t4_memdi_hold", 32'(MEM_DI), 32'hA5);

    // 2: sideways RAM write, bank 5; ROMSEL/data change mid-slot must not leak
    run_to(0);
    ROMSEL = 4'd5; MEM_ADR = 16'h8001; MEM_WE = 1'b1; MEM_DO = 8'h3C;
    step();
    chk("t2_a_ph1", 32'(SRAM_A), 32'h54001);
    chk("t2_do_ph1", 32'(SRAM_DO), 32'h3C);
    chk("t2_dqoe_ph1", 32'(SRAM_DQ_OE), 32'd1);
    chk("t2_nwe_ph1", 32'(SRAM_nWE), 32'd1);
    chk("t2_noe_ph1", 32'(SRAM_nOE), 32'd1);
    ROMSEL = 4'd2; MEM_DO = 8'hEE;
    step();
    chk("t2_nwe_ph2", 32'(SRAM_nWE), 32'd0);
    chk("t2_a_ph2", 32'(SRAM_A), 32'h54001);
    chk("t2_do_ph2", 32'(SRAM_DO), 32'h3C);
    step();
    chk("t2_nwe_ph3", 32'(SRAM_nWE), 32'd0);
    step();
    chk("t2_nwe_ph4", 32'(SRAM_nWE), 32'd1);
    chk("t2_dqoe_ph4", 32'(SRAM_DQ_OE), 32'd1);
    step();
    chk("t2_dqoe_ph5", 32'(SRAM_DQ_OE), 32'd0);
    chk("t2_mem", 32'(mem[19'h54001]), 32'h3C);
    chk("t2_memdi_hold", 32'(MEM_DI), 32'hA5);

    // 3: writes to protected bank 2 and to MOS are dropped and read instead
    run_to(0);
    ROMSEL = 4'd2; MEM_ADR = 16'h8001; MEM_WE = 1'b1; MEM_DO = 8'h77;
    wr0 = wr_lows;
    step();
    chk("t3_a_bank2", 32'(SRAM_A), 32'h48001);
    chk("t3_dqoe_bank2", 32'(SRAM_DQ_OE), 32'd0);
    chk("t3_noe_bank2", 32'(SRAM_nOE), 32'd0);
    run_to(5);
    chk("t3_memdi_bank2", 32'(MEM_DI), 32'h11);
    chk("t3_nwe_bank2", 32'(wr_lows), 32'(wr0));
    chk("t3_mem_bank2", 32'(mem[19'h48001]), 32'h11);
    run_to(0);
    MEM_ADR = 16'hC000; MEM_DO = 8'h99;
    step();
    chk("t3_a_mos", 32'(SRAM_A), 32'h0C000);
    run_to(5);
    chk("t3_memdi_mos", 32'(MEM_DI), 32'h22);
    chk("t3_nwe_mos", 32'(wr_lows), 32'(wr0));
    chk("t3_mem_mos", 32'(mem[19'h0C000]), 32'h22);

    // 5: early MEM_SYNC aborts a write before its strobe
    run_to(0);
    ROMSEL = 4'd0; MEM_ADR = 16'h0100; MEM_WE = 1'b1; MEM_DO = 8'h44;
    wr0 = wr_lows;
    step();
    chk("t5_dqoe_ph1", 32'(SRAM_DQ_OE), 32'd1);
    MEM_SYNC = 1'b1;
    step();
    chk("t5_phase", 32'(ph), 32'd0);
    chk("t5_nwe", 32'(SRAM_nWE), 32'd1);
    chk("t5_dqoe", 32'(SRAM_DQ_OE), 32'd0);
    chk("t5_nce", 32'(SRAM_nCE), 32'd1);
    MEM_WE = 1'b0;
    step();
    chk("t5_restart_nce", 32'(SRAM_nCE), 32'd0);
    chk("t5_restart_noe", 32'(SRAM_nOE), 32'd0);
    chk("t5_mem", 32'(mem[19'h00100]), 32'h55);
    chk("t5_no_strobe", 32'(wr_lows), 32'(wr0));
    run_to(5);
    chk("t5_memdi", 32'(MEM_DI), 32'h55);

    // 6: reset during phase 3 of a write
    run_to(0);
    MEM_ADR = 16'h0200; MEM_WE = 1'b1; MEM_DO = 8'h66;
    run_to(3);
    chk("t6_nwe_ph3", 32'(SRAM_nWE), 32'd0);
    nRESET = 1'b0;
    step();
    chk_reset_vals("t6");
    nRESET = 1'b1; MEM_WE = 1'b0;
    step();
    chk("t6_restart_nce", 32'(SRAM_nCE), 32'd0);
    chk("t6_restart_a", 32'(SRAM_A), 32'h00200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
